// File: rtl/aes_blk_stream.sv
// Valid/ready streaming wrapper for the AES-128 core. It packs four 32-bit words into one block,
// pulses ld_o once, and captures the ciphertext on done_i. It then returns the ciphertext as four words.
module aes_blk_stream #(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ld_o,
  output logic [127:0]     text_o,
  input  logic             done_i,
  input  logic [127:0]     text_i,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] blk_cnt_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {FILL, LOAD, WAIT, DRAIN} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [TW-1:0] tmo_cnt;
  logic [127:0]  obuf;
  logic [6:0]    lane;

  // Big-endian lanes: word 0 lives in [127:96], word 3 in [31:0], both directions.
  assign lane = {~idx, 5'd0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      tmo_cnt   <= '0;
      text_o    <= '0;
      obuf      <= '0;
      err_o     <= 1'b0;
      blk_cnt_o <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_valid) begin
            text_o[lane +: 32] <= in_data;
            idx                <= idx + 2'd1;
            if (idx == 2'd3) state <= LOAD;
          end
        end
        LOAD: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // done_i takes priority over the timeout limit in the same cycle
          if (done_i) begin
            obuf  <= text_i;
            state <= DRAIN;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            err_o <= 1'b1;
            state <= FILL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              blk_cnt_o <= blk_cnt_o + 1'b1;
              state     <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign in_ready  = (state == FILL) && !rst;
  assign ld_o      = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? obuf[lane +: 32] : 32'd0;
  assign busy_o    = (state != FILL) || (idx != 2'd0);

endmodule

// File: tb/tb_aes_blk_stream.sv
// Bench for aes_blk_stream. A cycle-level model of the core and stream endpoints predicts
// every output each cycle from block-level rules: packing, one ld per block, timeout and counting.
module tb_aes_blk_stream;
  localparam int TIMEOUT = 32;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             ld_o;
  logic [127:0]     text_o;
  logic             done_i = 1'b0;
  logic [127:0]     text_i = '0;
  logic             busy_o;
  logic             err_o;
  logic [CNT_W-1:0] blk_cnt_o;

  always #5 clk = ~clk;

  aes_blk_stream #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ld_o(ld_o), .text_o(text_o), .done_i(done_i), .text_i(text_i),
    .busy_o(busy_o), .err_o(err_o), .blk_cnt_o(blk_cnt_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // reference model state
  logic [31:0]      src_q[$];
  logic [31:0]      exp_out_q[$];
  logic [31:0]      blk_words[4];
  logic [127:0]     exp_block;
  logic [CNT_W-1:0] m_blk;
  int  in_words, out_words, age, core_lat, in_mode, out_mode, cyc;
  bit  inflight, exp_ld, waiting, draining, m_err;
  bit  core_dead, force_done, spur, rand_lat;

  task automatic clear_model();
    src_q.delete();
    exp_out_q.delete();
    in_words = 0; out_words = 0; age = 0;
    inflight = 0; exp_ld = 0; waiting = 0; draining = 0; m_err = 0;
    m_blk = '0;
  endtask

  task automatic observe();
    cyc++;
    if (waiting) begin
      age++;
      // 32 cycles spent waiting with no done: the block is dropped
      if (age == TIMEOUT + 1) begin
        waiting = 0; inflight = 0; m_err = 1;
      end
    end
    check("ld_o", ld_o, exp_ld);
    if (exp_ld) begin
      check("text_o_at_ld", text_o, exp_block);
      waiting = 1; age = 0; exp_ld = 0;
      if (rand_lat) core_lat = $urandom_range(1, TIMEOUT);
    end
    check("in_ready", in_ready, !inflight);
    check("busy_o", busy_o, inflight || (in_words != 0));
    check("out_valid", out_valid, draining);
    if (draining && exp_out_q.size() > 0) check("out_data", out_data, exp_out_q[0]);
    check("err_o", err_o, m_err);
    check("blk_cnt_o", blk_cnt_o, m_blk);
  endtask

  task automatic drive();
    logic [127:0] ct;
    bit gate;
    done_i = 0;
    text_i = {$urandom, $urandom, $urandom, $urandom};
    if (waiting && !core_dead && age == core_lat) begin
      ct = ~exp_block;
      done_i = 1; text_i = ct;
      waiting = 0; draining = 1; out_words = 0;
      for (int i = 0; i < 4; i++) exp_out_q.push_back(ct[127 - 32*i -: 32]);
    end else if (force_done) begin
      done_i = 1; force_done = 0;
    end else if (spur && !waiting && !draining) begin
      done_i = 1'($urandom_range(0, 1));
    end

    case (in_mode)
      0:       gate = 1;
      1:       gate = cyc[0];
      default: gate = 1'($urandom_range(0, 1));
    endcase
    in_valid = gate && (src_q.size() > 0);
    in_data  = in_valid ? src_q[0] : $urandom;
    if (in_valid && in_ready) begin
      blk_words[in_words] = src_q.pop_front();
      in_words++;
      if (in_words == 4) begin
        exp_block = {blk_words[0], blk_words[1], blk_words[2], blk_words[3]};
        in_words = 0; inflight = 1; exp_ld = 1;
      end
    end

    case (out_mode)
      0:       out_ready = 1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (out_valid && out_ready && exp_out_q.size() > 0) begin
      void'(exp_out_q.pop_front());
      out_words++;
      if (out_words == 4) begin
        draining = 0; inflight = 0; m_blk++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    drive();
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0; done_i = 0;
    #1 check("in_ready_in_reset", in_ready, 0);
    @(negedge clk);
    rst = 0;
    clear_model();
    check("text_o_reset", text_o, 0);
    check("out_data_reset", out_data, 0);
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((src_q.size() > 0 || inflight || in_words != 0 || exp_ld) && n < max) begin
      tick();
      n++;
    end
    check("reached_idle", (src_q.size() == 0 && !inflight && in_words == 0), 1);
    tick();
  endtask

  task automatic push_block(input logic [127:0] b);
    for (int i = 0; i < 4; i++) src_q.push_back(b[127 - 32*i -: 32]);
  endtask

  initial begin
    int n;
    cyc = 0; core_lat = 11; in_mode = 0; out_mode = 0;
    core_dead = 0; force_done = 0; spur = 0; rand_lat = 0;
    clear_model();
    do_reset();
    tick();

    // directed block, free-flowing output
    push_block(128'h00112233445566778899aabbccddeeff);
    run_idle(200);
    check("t1_blk_cnt", blk_cnt_o, 1);

    // same block, output stalls 1,0,0 repeating
    out_mode = 1;
    push_block(128'h00112233445566778899aabbccddeeff);
    run_idle(300);
    check("t2_blk_cnt", blk_cnt_o, 2);
    out_mode = 0;

    // core never answers: timeout, then a block whose done lands on the limit cycle
    core_dead = 1;
    push_block({$urandom, $urandom, $urandom, $urandom});
    run_idle(200);
    check("t3_err", err_o, 1);
    check("t3_blk_cnt", blk_cnt_o, 2);
    core_dead = 0; core_lat = TIMEOUT;
    push_block({$urandom, $urandom, $urandom, $urandom});
    run_idle(200);
    check("t3_err_sticky", err_o, 1);
    check("t3_blk_after", blk_cnt_o, 3);

    // reset while waiting on the core, then a late done
    core_lat = 20;
    push_block({$urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (!(waiting && age == 5) && n < 100) begin tick(); n++; end
    check("t4_reached_wait", waiting, 1);
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    force_done = 1;
    for (int i = 0; i < 6; i++) tick();
    check("t4_out_valid", out_valid, 0);
    check("t4_blk_cnt", blk_cnt_o, 0);

    // gapped input with spurious done during fill
    in_mode = 1; spur = 1; core_lat = 11;
    for (int b = 0; b < 3; b++) push_block({$urandom, $urandom, $urandom, $urandom});
    run_idle(400);
    check("t6_blk_cnt", blk_cnt_o, 3);
    spur = 0;

    // random traffic and latencies; counter wraps past all-ones
    in_mode = 2; out_mode = 2; rand_lat = 1; core_lat = $urandom_range(1, TIMEOUT);
    for (int b = 0; b < 18; b++) push_block({$urandom, $urandom, $urandom, $urandom});
    run_idle(4000);
    check("t5_blk_wrapped", blk_cnt_o, 4'(3 + 18));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_blk_stream.md
Name: aes_blk_stream

Overview:
- Single-clock streaming front/back end for the AES-128 cipher core (aes_cipher_top).
- Packs a 32-bit word stream into 128-bit plaintext blocks and issues one load pulse per block to the core.
- Captures the core's ciphertext on done and unpacks it into a 32-bit output stream.
- Sits between the Wishbone-side data path and the cipher core, replacing per-word register pokes with valid/ready streams.

Parameters:
- TIMEOUT, 32, maximum cycles spent in WAIT for done_i before abort (core nominal latency ~11 cycles).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  32  plaintext word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  32  ciphertext word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- ld_o  out  1  one-cycle load pulse to core (core ld).
- text_o  out  128  plaintext block to core (core text_in).
- done_i  in  1  core done pulse.
- text_i  in  128  core ciphertext (core text_out).
- busy_o  out  1  high in any state other than FILL with word count 0.
- err_o  out  1  sticky timeout flag.
- blk_cnt_o  out  CNT_W  completed blocks, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at edge), regardless of state:
  - state=FILL, word index=0.
  - in_ready=0 during the reset cycle, then 1.
  - out_valid=0, ld_o=0, text_o=0, out_data=0, err_o=0, blk_cnt_o=0, busy_o=0.
  - A core operation in flight is abandoned; a later done_i is ignored because state is not WAIT.
- Word order is big-endian: the first word goes to bits [127:96], the fourth to [31:0]. The same order applies on output.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready, the word is written into text_o at the current index and the index increments.
  - On accepting the 4th word: index→0, next state LOAD.
- LOAD:
  - ld_o=1 for exactly this one cycle; text_o is stable and complete.
  - in_ready=0.
  - Next state WAIT; the timeout counter clears.
- WAIT:
  - in_ready=0.
  - On done_i=1: register text_i into the output buffer, next state DRAIN.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no done_i: set err_o, discard the block, next state FILL. blk_cnt_o does not change.
  - done_i in the same cycle as the timeout limit counts as done (done wins).
  - done_i in any state other than WAIT is ignored.
- DRAIN:
  - out_valid=1; out_data = buffer word at the output index.
  - On out_valid&out_ready, the index increments. After the 4th word: out_valid→0 next cycle, blk_cnt_o increments (wrapping from all-ones to 0), next state FILL.
  - out_data/out_valid stay stable while out_ready=0, with no limit on stall length.
  - in_ready=0 throughout (no overlap between blocks).
- Timing:
  - Latency from 4th input word accepted to ld_o: 1 cycle.
  - Latency from done_i to first out_valid: 1 cycle.
  - Minimum block period: 4 + 1 + core latency + 1 + 4 cycles.
- in_valid while in_ready=0: the word is not consumed; the upstream side holds it.
- text_o holds its last value after LOAD until overwritten by the next FILL.
- err_o is cleared only by rst.
- busy_o=1 in LOAD, WAIT and DRAIN, and in FILL when index≠0.

Test Plan:
1. Reset, then stream 00112233, 44556677, 8899aabb, ccddeeff with in_valid continuous; core model returns ~text 11 cycles after ld -> ld_o single pulse one cycle after 4th accept; text_o=00112233445566778899aabbccddeeff at ld; outputs ffeeddcc, bbaa9988, 77665544, 33221100 in order; blk_cnt_o=1.
2. Same stimulus with out_ready toggling 1,0,0,1,… -> each word held stable while stalled; no word dropped or duplicated; in_ready stays 0 until the last word is accepted.
3. Core model never asserts done_i, TIMEOUT=32 -> err_o=1 exactly 32 cycles after ld_o; state returns to FILL (in_ready=1); blk_cnt_o unchanged; a following valid block completes normally and err_o stays 1.
4. Assert rst in WAIT, then have the core model fire done_i 5 cycles after rst deasserts -> done_i ignored; out_valid stays 0; all outputs at reset values.
5. Preload blk_cnt to 0xFFFF (run 65535 blocks, or force) and complete one block -> blk_cnt_o=0x0000.
6. Drive in_valid with gaps (1,0,1,0,…) and spurious done_i during FILL -> only valid words packed; no ld_o before the 4th word; spurious done_i has no effect.
